updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit up-counter.
- Adds: configurable width and modulus, up/down direction, synchronous clear and parallel load, wrap or saturate mode, terminal-count and wrap/saturate event outputs.
- Used as a general timing/event counter in datapath and control blocks; one clock domain.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, highest count value (modulus-1); must be <= 2**WIDTH-1 and >=1.
- RESET_VAL, 0, value of count after async reset and after clr; must be <= MAX_VAL.
- PRESCALE_DIV, 4, enabled-cycle divide ratio (>=1); used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up_dn  in  1  direction: 1=up, 0=down.
- sat_mode  in  1  0=wrap at limits, 1=saturate at limits.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational: (up_dn && count==MAX_VAL) || (!up_dn && count==0).
- wrap_pulse  out  1  registered; high for exactly one cycle after a wrap step.
- sat_hit  out  1  registered; high for one cycle after a step request blocked by saturation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=RESET_VAL, wrap_pulse=0, sat_hit=0, prescaler=0.
  - Deassertion is taken synchronously by the next edge.
- Priority per edge: clr > load > step > hold.
- clr: count<=RESET_VAL; wrap_pulse, sat_hit <=0; prescaler <=0.
- load: count<=min(load_val, MAX_VAL); out-of-range load_val is clamped, never wrapped. wrap_pulse, sat_hit <=0; prescaler <=0.
- A step occurs when en=1 and no clr or load is active (with the optional feature: only on the prescaler tick).
- Up step:
  - count<MAX_VAL -> count+1.
  - count==MAX_VAL, wrap mode -> 0, wrap_pulse<=1.
  - count==MAX_VAL, saturate mode -> hold, sat_hit<=1.
- Down step:
  - count>0 -> count-1.
  - count==0, wrap mode -> MAX_VAL, wrap_pulse<=1.
  - count==0, saturate mode -> hold, sat_hit<=1.
- wrap_pulse and sat_hit are 0 in every cycle without the corresponding event; they are never sticky.
- Arithmetic is done in WIDTH bits. count never exceeds MAX_VAL; with non-power-of-two MAX_VAL, natural binary rollover must not occur.
- up_dn and sat_mode are sampled each edge; a change takes effect on that same step.
- en=0 holds count; tc still tracks up_dn combinationally.
- Async reset mid-operation overrides everything immediately.

Optional Feature:
- Macro: UPDOWN_COUNTER_PRESCALE_EN.
- Defined:
  - A prescaler of width $clog2(PRESCALE_DIV)+1 increments on each cycle with en=1 and no clr/load.
  - A step occurs only on the cycle the prescaler equals PRESCALE_DIV-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - clr, load and reset zero it.
  - PRESCALE_DIV=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; every en cycle is a step; PRESCALE_DIV is ignored.

Decomposition:
- Package updown_counter_pkg:
  - typedef enum logic {CNT_DOWN=1'b0, CNT_UP=1'b1} cnt_dir_e.
  - typedef enum logic {CNT_WRAP=1'b0, CNT_SAT=1'b1} cnt_mode_e.
  - Elaboration-time parameter checks, as a function or assertion, on MAX_VAL/RESET_VAL legality.
- Sub-module counter_prescaler:
  - Parameter PRESCALE_DIV; ports clk, rst_n, clr, en, tick.
  - Instantiated only under UPDOWN_COUNTER_PRESCALE_EN.

Test Plan (WIDTH=4, MAX_VAL=9, RESET_VAL=0 unless stated):
- Reset then en=1, up, wrap mode, 12 cycles -> count 1..9,0,1,2; wrap_pulse high only the cycle count shows 0; tc=1 while count==9.
- load=1 with load_val=15 -> count=9 (clamped). Then down, saturate mode, 11 en cycles -> 8..0, then held at 0; sat_hit=1 on each blocked step.
- clr, load and en all high with count=5 -> count=RESET_VAL; with RESET_VAL=3 build -> count=3. Load and en together -> loaded value, no step.
- Assert rst_n=0 mid-count at count=6 between edges -> count=0 immediately, pulses 0; release -> counting resumes from 0 on the following en edge.
- Toggle up_dn each cycle from count=0, wrap mode -> 0->9 (wrap), 9->0? No: the up step at 9 wraps to 0 with wrap_pulse. Check each wrap_pulse against a reference model.
- With UPDOWN_COUNTER_PRESCALE_EN, PRESCALE_DIV=4, en=1 for 8 cycles with one en=0 gap -> 2 steps, gap delays the second step by 1 cycle. Without the macro -> 8 steps.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types and parameter legality check for updown_mod_counter
package updown_counter_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP  = 1'b1} cnt_dir_e;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

  // Evaluated at elaboration; a false result stops the build in the top module.
  function automatic bit cnt_params_ok(input int width, input longint max_val,
                                       input longint reset_val, input int prescale_div);
    longint top_val;
    top_val = (longint'(1) << width) - 1;
    return (width >= 2) && (width <= 31) &&
           (max_val >= 1) && (max_val <= top_val) &&
           (reset_val >= 0) && (reset_val <= max_val) &&
           (prescale_div >= 1);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enabled-cycle divider producing one tick every PRESCALE_DIV enabled cycles
module counter_prescaler #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE_DIV) + 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] div_q;
  logic [PW-1:0] div_d;

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      if (div_q == LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with wrap/saturate, clear, load and event pulses
// Optional enabled-cycle prescaler via `define UPDOWN_COUNTER_PRESCALE_EN.
module updown_mod_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_VAL      = 2**WIDTH - 1,
  parameter int RESET_VAL    = 0,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             sat_hit
);

  if (!cnt_params_ok(WIDTH, MAX_VAL, RESET_VAL, PRESCALE_DIV)) begin : g_param_check
    $error("updown_mod_counter: illegal WIDTH/MAX_VAL/RESET_VAL/PRESCALE_DIV");
  end

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             sat_hit_q, sat_hit_d;
  logic             step_tick;
  logic             step;
  logic             at_limit;
  cnt_dir_e         dir;
  cnt_mode_e        mode;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr | load),
    .en   (en),
    .tick (step_tick)
  );
`else
  assign step_tick = en;
`endif

  assign dir  = cnt_dir_e'(up_dn);
  assign mode = cnt_mode_e'(sat_mode);
  assign step = step_tick && !clr && !load;

  // Limit depends on the live direction, so tc follows up_dn even while held.
  assign at_limit = (dir == CNT_UP) ? (count_q == MAX_C) : (count_q == '0);

  always_comb begin
    count_d      = count_q;
    wrap_pulse_d = 1'b0;
    sat_hit_d    = 1'b0;
    if (clr) begin
      count_d = RESET_C;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (step) begin
      if (!at_limit) begin
        count_d = (dir == CNT_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else if (mode == CNT_WRAP) begin
        count_d      = (dir == CNT_UP) ? '0 : MAX_C;
        wrap_pulse_d = 1'b1;
      end else begin
        sat_hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= RESET_C;
      wrap_pulse_q <= 1'b0;
      sat_hit_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_pulse_q <= wrap_pulse_d;
      sat_hit_q    <= sat_hit_d;
    end
  end

  assign count      = count_q;
  assign tc         = at_limit;
  assign wrap_pulse = wrap_pulse_q;
  assign sat_hit    = sat_hit_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter (WIDTH=4, MAX_VAL=9)
module tb_updown_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam int PDIV = 4;
`else
  localparam int PDIV = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         sat_mode = 1'b0;
  logic [W-1:0] count, count3;
  logic         tc, tc3, wrap_pulse, wp3, sat_hit, sh3;

  int checks = 0;
  int failures = 0;

  int m_cnt = 0;
  int m_pre = 0;
  bit m_wp = 0;
  bit m_sh = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(0), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .count(count), .tc(tc),
    .wrap_pulse(wrap_pulse), .sat_hit(sat_hit)
  );

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(3), .PRESCALE_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .count(count3), .tc(tc3),
    .wrap_pulse(wp3), .sat_hit(sh3)
  );

  typedef struct {
    logic c, l;
    logic [W-1:0] lv;
    logic e, u, s;
    int   cnt;
    logic wp, sh, tcx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic l, int lv, logic e, logic u, logic s,
                              int cnt, logic wp, logic sh, logic tcx);
    vec_t v;
    v.c = c; v.l = l; v.lv = W'(lv); v.e = e; v.u = u; v.s = s;
    v.cnt = cnt; v.wp = wp; v.sh = sh; v.tcx = tcx;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic c, input logic l, input int lv, input logic e,
                        input logic u, input logic s);
    clr = c; load = l; load_val = W'(lv); en = e; up_dn = u; sat_mode = s;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_wp = 0; m_sh = 0;
  endtask

  // Reference: priority clr > load > step, step every PDIV-th enabled cycle.
  task automatic model_edge();
    bit tick;
    tick = 0;
    m_wp = 0;
    m_sh = 0;
    if (clr) begin
      m_cnt = 0; m_pre = 0;
    end else if (load) begin
      m_cnt = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_pre = 0;
    end else if (en) begin
      m_pre = (m_pre + 1) % PDIV;
      tick  = (m_pre == 0);
    end
    if (tick) begin
      if (up_dn) begin
        if (m_cnt < MAXV) m_cnt = m_cnt + 1;
        else if (!sat_mode) begin m_cnt = 0; m_wp = 1; end
        else m_sh = 1;
      end else begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else if (!sat_mode) begin m_cnt = MAXV; m_wp = 1; end
        else m_sh = 1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    int m_tc;
    @(posedge clk);
    model_edge();
    #1;
    m_tc = up_dn ? int'(m_cnt == MAXV) : int'(m_cnt == 0);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(m_wp));
    chk({tag, ".sat_hit"}, int'(sat_hit), int'(m_sh));
    chk({tag, ".tc"}, int'(tc), m_tc);
  endtask

  initial begin
    bit en_pat[9];
    en_pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1};

    #12;
    chk("reset.count", int'(count), 0);
    chk("reset.wrap_pulse", int'(wrap_pulse), 0);
    chk("reset.sat_hit", int'(sat_hit), 0);
    chk("reset.count_rv3", int'(count3), 3);
    rst_n = 1'b1;
    model_reset();

`ifndef UPDOWN_COUNTER_PRESCALE_EN
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, i % 10, (i == 10), 0, (i == 9)));
    tbl.push_back(mk(0, 1, 15, 0, 0, 1, 9, 0, 0, 0));
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, (i <= 9) ? 9 - i : 0, 0, (i > 9), (i >= 9)));
    tbl.push_back(mk(0, 1, 5, 0, 1, 0, 5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 1, 1, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 9, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 9, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      set_in(tbl[i].c, tbl[i].l, int'(tbl[i].lv), tbl[i].e, tbl[i].u, tbl[i].s);
      cycle("tbl_model");
      chk($sformatf("tbl[%0d].count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl[%0d].wrap_pulse", i), int'(wrap_pulse), int'(tbl[i].wp));
      chk($sformatf("tbl[%0d].sat_hit", i), int'(sat_hit), int'(tbl[i].sh));
      chk($sformatf("tbl[%0d].tc", i), int'(tc), int'(tbl[i].tcx));
      if (tbl[i].c) chk($sformatf("tbl[%0d].count_rv3", i), int'(count3), 3);
    end
`endif

    // Async reset between edges while counting
    set_in(0, 1, 6, 0, 1, 0);
    cycle("pre_rst");
    set_in(0, 0, 0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.count", int'(count), 0);
    chk("async_rst.wrap_pulse", int'(wrap_pulse), 0);
    chk("async_rst.sat_hit", int'(sat_hit), 0);
    chk("async_rst.count_rv3", int'(count3), 3);
    model_reset();
    #2 rst_n = 1'b1;
    cycle("post_rst");

    // Direction toggling every cycle in wrap mode
    set_in(1, 0, 0, 0, 1, 0);
    cycle("toggle_clr");
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 1, logic'(i % 2), 0);
      cycle("toggle");
    end

    // Enable pattern with one gap, from zero
    set_in(1, 0, 0, 0, 1, 0);
    cycle("pre_clr");
    foreach (en_pat[i]) begin
      set_in(0, 0, 0, en_pat[i], 1, 0);
      cycle("prescale");
    end
    chk("prescale.steps", int'(count), (PDIV == 4) ? 2 : 8);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
